crono_regresivo: RTL and testbench
==================================

Name: crono_regresivo

Overview:
- Countdown engine for the stopwatch/timer display path. Holds an hh:mm:ss value that is edited field-by-field with up/down buttons.
- On start, decrements the value once per 1 Hz tick and raises an alarm on reaching 00:00:00.
- Sits between the button debouncers / 1 Hz divider and the display formatter, and drives the same field widths the display already consumes.

Parameters:
- HR_MAX, 23, highest hour value; hour field wraps/saturates against it.
- ALARM_TICKS, 10, number of tick_1hz pulses the alarm stays asserted if not acknowledged.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-clk-wide pulse once per second
- EN  in  2  field select for editing: 0 none, 1 minutes, 2 seconds, 3 hours
- aumento  in  1  one-clk pulse, increment selected field
- disminuye  in  1  one-clk pulse, decrement selected field
- start  in  1  one-clk pulse, begin countdown
- stop  in  1  one-clk pulse, pause countdown / acknowledge alarm
- crono_hr  out  5  hours remaining
- crono_min  out  6  minutes remaining
- crono_seg  out  6  seconds remaining
- corriendo  out  1  high while counting down
- alarma  out  1  high while alarm active

Behaviour:
- Reset
  - Reset is clk / rst, synchronous, active-high.
  - Reset values: crono_hr=0, crono_min=0, crono_seg=0, corriendo=0, alarma=0, state=IDLE, alarm counter=0.
  - Reset has priority over every other input in every state, including mid-countdown and mid-alarm.
- States: IDLE (editable, stopped), RUN (counting), ALARM (value 0, alarma high). corriendo=1 only in RUN; alarma=1 only in ALARM. Both are registered.
- Editing (IDLE only; ignored in RUN and ALARM)
  - Acts on the field chosen by EN; EN=0 means no change.
  - aumento has priority over disminuye when both are pulsed.
  - aumento: field+1. Minutes/seconds wrap 59->0; hours wrap HR_MAX->0. There is no carry into other fields.
  - disminuye: field-1, saturating at 0. There is no borrow.
  - Result is visible one clk after the pulse.
- IDLE->RUN
  - On start when the value is non-zero.
  - start with value 00:00:00 is ignored; the block stays in IDLE.
- RUN
  - Each tick_1hz decrements the value by one second, updated the clk after the tick.
  - Borrow chain: seg 0 -> 59 with min-1; min 0 -> 59 with hr-1.
  - If the decrement produces 00:00:00, the next state is ALARM, with alarma=1 and corriendo=0 in the same update.
- RUN->IDLE on stop; the value is held.
  - stop and tick in the same cycle: stop wins and there is no decrement.
  - start and stop in the same cycle: stop wins, in any state.
- ALARM
  - Value is held at 0.
  - The counter counts tick_1hz pulses. After ALARM_TICKS ticks, or on stop, the block goes to IDLE with alarma=0 the next clk.
  - start in ALARM is ignored.
- Widths
  - All arithmetic is done at field width.
  - Values above 59 (min/seg) or above HR_MAX (hr) are never produced.
  - The alarm counter is sized by $clog2(ALARM_TICKS+1).

Decomposition:
- Shared package crono_pkg:
  - state enum {IDLE, RUN, ALARM}
  - EN field codes: SEL_NONE=0, SEL_MIN=1, SEL_SEG=2, SEL_HR=3
  - constant SEG_MAX=59, MIN_MAX=59
- One sub-module, crono_campo: a single modulo field with inputs inc/dec/borrow_in, parameter MAX, outputs value and borrow_out. It is instantiated three times: seg, min, hr.
- FSM and alarm counter stay in the top level.

Test Plan:
- rst mid-RUN at 00:01:30 -> next clk all outputs 0, corriendo=0, alarma=0, state IDLE.
- Edit checks:
  - EN=1, seven aumento pulses from 0 -> crono_min=7.
  - EN=2, disminuye from 0 -> crono_seg stays 0.
  - EN=1, aumento at 59 -> crono_min=0.
  - EN=3, aumento at HR_MAX -> crono_hr=0.
- Countdown checks:
  - Set 01:00:00, start, one tick -> 00:59:59, corriendo=1.
  - Set 00:00:02, start, two ticks -> 00:00:00 with alarma=1 and corriendo=0 one clk after the second tick.
- Alarm exit:
  - In ALARM, 10 ticks -> alarma drops, IDLE.
  - Repeat with stop after 3 ticks -> alarma drops the next clk.
- Simultaneous inputs:
  - start with 00:00:00 -> corriendo stays 0.
  - In RUN at 00:00:05, stop coincident with tick -> value stays 00:00:05, IDLE.
  - aumento+disminuye together on seg=10 -> 11.
- Editing blocked in RUN: EN=2, aumento during RUN -> no change to crono_seg other than tick decrements.

Source files
------------

// File: rtl/crono_pkg.sv
// Shared types and constants for the countdown engine.
// State encoding, edit field codes and field limits.
package crono_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_MIN  = 2'd1;
    localparam logic [1:0] SEL_SEG  = 2'd2;
    localparam logic [1:0] SEL_HR   = 2'd3;

    localparam int SEG_MAX = 59;
    localparam int MIN_MAX = 59;

endpackage

// File: rtl/crono_campo.sv
// One modulo time field: wrap-around increment, saturating edit
// decrement, and a borrowing countdown decrement.
module crono_campo #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         borrow_in,
    output logic [W-1:0] value,
    output logic         borrow_out
);

    localparam logic [W-1:0] TOP = W'(MAX);

    logic [W-1:0] next;

    always_comb begin
        next = value;
        if (inc)
            next = (value == TOP) ? '0 : value + W'(1);
        else if (dec)
            next = (value == '0) ? '0 : value - W'(1);
        else if (borrow_in)
            next = (value == '0) ? TOP : value - W'(1);
    end

    // A countdown step through zero asks the next field up to give one.
    assign borrow_out = borrow_in && (value == '0);

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else
            value <= next;
    end

endmodule

// File: rtl/crono_regresivo.sv
// Countdown timer: hh:mm:ss edited per field in IDLE, decremented
// once per tick in RUN, alarm held for a bounded number of ticks.
module crono_regresivo
    import crono_pkg::*;
#(
    parameter int HR_MAX      = 23,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [1:0] EN,
    input  logic       aumento,
    input  logic       disminuye,
    input  logic       start,
    input  logic       stop,
    output logic [4:0] crono_hr,
    output logic [5:0] crono_min,
    output logic [5:0] crono_seg,
    output logic       corriendo,
    output logic       alarma
);

    localparam int CW = $clog2(ALARM_TICKS + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(ALARM_TICKS - 1);

    state_t        estado, estado_sig;
    logic [CW-1:0] cnt, cnt_sig;

    logic editar, sube, baja, tick_dec;
    logic es_cero, es_uno;
    logic seg_borrow, min_borrow, hr_borrow_unused;

    assign editar   = (estado == IDLE);
    assign sube     = editar && aumento;
    assign baja     = editar && !aumento && disminuye;
    assign tick_dec = (estado == RUN) && tick_1hz && !stop;

    assign es_cero = (crono_hr == '0) && (crono_min == '0)
                  && (crono_seg == '0);
    assign es_uno  = (crono_hr == '0) && (crono_min == '0)
                  && (crono_seg == 6'd1);

    crono_campo #(.W(6), .MAX(SEG_MAX)) u_seg (
        .clk        (clk),
        .rst        (rst),
        .inc        (sube && (EN == SEL_SEG)),
        .dec        (baja && (EN == SEL_SEG)),
        .borrow_in  (tick_dec),
        .value      (crono_seg),
        .borrow_out (seg_borrow)
    );

    crono_campo #(.W(6), .MAX(MIN_MAX)) u_min (
        .clk        (clk),
        .rst        (rst),
        .inc        (sube && (EN == SEL_MIN)),
        .dec        (baja && (EN == SEL_MIN)),
        .borrow_in  (seg_borrow),
        .value      (crono_min),
        .borrow_out (min_borrow)
    );

    // The hour field never underflows: RUN leaves at 00:00:01.
    crono_campo #(.W(5), .MAX(HR_MAX)) u_hr (
        .clk        (clk),
        .rst        (rst),
        .inc        (sube && (EN == SEL_HR)),
        .dec        (baja && (EN == SEL_HR)),
        .borrow_in  (min_borrow),
        .value      (crono_hr),
        .borrow_out (hr_borrow_unused)
    );

    always_comb begin
        estado_sig = estado;
        cnt_sig    = '0;
        case (estado)
            IDLE: begin
                if (start && !stop && !es_cero)
                    estado_sig = RUN;
            end
            RUN: begin
                if (stop)
                    estado_sig = IDLE;
                else if (tick_dec && es_uno)
                    estado_sig = ALARM;
            end
            ALARM: begin
                cnt_sig = cnt;
                if (stop)
                    estado_sig = IDLE;
                else if (tick_1hz) begin
                    if (cnt == ULTIMO)
                        estado_sig = IDLE;
                    else
                        cnt_sig = cnt + CW'(1);
                end
            end
            default: estado_sig = IDLE;
        endcase
        if (estado_sig != ALARM)
            cnt_sig = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= IDLE;
            cnt       <= '0;
            corriendo <= 1'b0;
            alarma    <= 1'b0;
        end else begin
            estado    <= estado_sig;
            cnt       <= cnt_sig;
            corriendo <= (estado_sig == RUN);
            alarma    <= (estado_sig == ALARM);
        end
    end

endmodule

// File: tb/tb_crono_regresivo.sv
// Bench for crono_regresivo: vector table plus hand sequences,
// expected values queued at drive time and checked after the edge.
module tb_crono_regresivo;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, aumento, disminuye, start, stop;
    logic [1:0] EN;
    logic [4:0] crono_hr;
    logic [5:0] crono_min, crono_seg;
    logic       corriendo, alarma;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] mn;
        logic [5:0] sg;
        logic       co;
        logic       al;
    } exp_t;

    typedef struct {
        logic       r, t;
        logic [1:0] e;
        logic       a, d, s, p;
        exp_t       x;
    } vec_t;

    exp_t  sb[$];
    string tags[$];
    vec_t  tabla[26];

    crono_regresivo #(.HR_MAX(23), .ALARM_TICKS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .EN        (EN),
        .aumento   (aumento),
        .disminuye (disminuye),
        .start     (start),
        .stop      (stop),
        .crono_hr  (crono_hr),
        .crono_min (crono_min),
        .crono_seg (crono_seg),
        .corriendo (corriendo),
        .alarma    (alarma)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic comparar();
        exp_t  x, y;
        string tg;
        x  = sb.pop_front();
        tg = tags.pop_front();
        y  = '{crono_hr, crono_min, crono_seg, corriendo, alarma};
        checks++;
        if (y !== x) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d co=%0b al=%0b, want %0d:%0d:%0d co=%0b al=%0b",
                     tg, y.hr, y.mn, y.sg, y.co, y.al,
                     x.hr, x.mn, x.sg, x.co, x.al);
        end
    endtask

    task automatic cyc(input string tg, input logic r, input logic t,
                       input logic [1:0] e, input logic a, input logic d,
                       input logic s, input logic p, input exp_t x);
        rst = r; tick_1hz = t; EN = e;
        aumento = a; disminuye = d; start = s; stop = p;
        sb.push_back(x);
        tags.push_back(tg);
        @(posedge clk);
        #1;
        rst = 0; tick_1hz = 0; EN = 0;
        aumento = 0; disminuye = 0; start = 0; stop = 0;
        comparar();
    endtask

    function automatic exp_t ex(int h, int m, int s, bit c, bit a);
        return '{5'(h), 6'(m), 6'(s), c, a};
    endfunction

    function automatic vec_t v(bit r, bit t, int e, bit a, bit d,
                               bit s, bit p, exp_t x);
        return '{r, t, 2'(e), a, d, s, p, x};
    endfunction

    initial begin
        rst = 1; tick_1hz = 0; EN = 0;
        aumento = 0; disminuye = 0; start = 0; stop = 0;

        tabla[0]  = v(1,0,0,0,0,0,0, ex(0,0,0,0,0));
        for (int i = 1; i <= 7; i++)
            tabla[i] = v(0,0,1,1,0,0,0, ex(0,i,0,0,0));
        tabla[8]  = v(0,0,2,0,1,0,0, ex(0,7,0,0,0));
        tabla[9]  = v(0,0,0,1,0,0,0, ex(0,7,0,0,0));
        tabla[10] = v(0,0,3,1,0,0,0, ex(1,7,0,0,0));
        tabla[11] = v(0,0,3,0,1,0,0, ex(0,7,0,0,0));
        tabla[12] = v(0,0,2,1,0,0,0, ex(0,7,1,0,0));
        tabla[13] = v(0,0,0,0,0,1,0, ex(0,7,1,1,0));
        tabla[14] = v(0,0,2,1,0,0,0, ex(0,7,1,1,0));
        tabla[15] = v(0,1,0,0,0,0,0, ex(0,7,0,1,0));
        tabla[16] = v(0,1,0,0,0,0,0, ex(0,6,59,1,0));
        tabla[17] = v(0,1,2,1,0,0,0, ex(0,6,58,1,0));
        tabla[18] = v(0,1,0,0,0,0,1, ex(0,6,58,0,0));
        tabla[19] = v(0,0,0,0,0,1,1, ex(0,6,58,0,0));
        tabla[20] = v(1,0,0,0,0,0,0, ex(0,0,0,0,0));
        tabla[21] = v(0,0,0,0,0,1,0, ex(0,0,0,0,0));
        tabla[22] = v(0,0,3,1,0,0,0, ex(1,0,0,0,0));
        tabla[23] = v(0,0,0,0,0,1,0, ex(1,0,0,1,0));
        tabla[24] = v(0,1,0,0,0,0,0, ex(0,59,59,1,0));
        tabla[25] = v(1,0,0,0,0,0,0, ex(0,0,0,0,0));

        for (int i = 0; i < 26; i++)
            cyc($sformatf("vec%0d", i), tabla[i].r, tabla[i].t,
                tabla[i].e, tabla[i].a, tabla[i].d, tabla[i].s,
                tabla[i].p, tabla[i].x);

        // reset in the middle of a countdown at 00:01:30
        cyc("mr_min", 0,0,1,1,0,0,0, ex(0,1,0,0,0));
        for (int i = 1; i <= 30; i++)
            cyc("mr_seg", 0,0,2,1,0,0,0, ex(0,1,i,0,0));
        cyc("mr_start", 0,0,0,0,0,1,0, ex(0,1,30,1,0));
        cyc("mr_rst", 1,1,2,1,0,1,0, ex(0,0,0,0,0));
        cyc("mr_idle", 0,0,0,0,0,0,0, ex(0,0,0,0,0));

        // minute wrap 59 -> 0
        for (int i = 1; i <= 59; i++)
            cyc("min_up", 0,0,1,1,0,0,0, ex(0,i,0,0,0));
        cyc("min_wrap", 0,0,1,1,0,0,0, ex(0,0,0,0,0));

        // hour wrap HR_MAX -> 0, then saturating decrement
        for (int i = 1; i <= 23; i++)
            cyc("hr_up", 0,0,3,1,0,0,0, ex(i,0,0,0,0));
        cyc("hr_wrap", 0,0,3,1,0,0,0, ex(0,0,0,0,0));
        cyc("hr_sat", 0,0,3,0,1,0,0, ex(0,0,0,0,0));

        // aumento beats disminuye on seg=10
        for (int i = 1; i <= 10; i++)
            cyc("seg_up", 0,0,2,1,0,0,0, ex(0,0,i,0,0));
        cyc("both", 0,0,2,1,1,0,0, ex(0,0,11,0,0));
        cyc("rst2", 1,0,0,0,0,0,0, ex(0,0,0,0,0));

        // 00:00:02 down to alarm, then timeout after 10 ticks
        cyc("a_set1", 0,0,2,1,0,0,0, ex(0,0,1,0,0));
        cyc("a_set2", 0,0,2,1,0,0,0, ex(0,0,2,0,0));
        cyc("a_start", 0,0,0,0,0,1,0, ex(0,0,2,1,0));
        cyc("a_tick1", 0,1,0,0,0,0,0, ex(0,0,1,1,0));
        cyc("a_tick2", 0,1,0,0,0,0,0, ex(0,0,0,0,1));
        cyc("a_start_ign", 0,0,0,0,0,1,0, ex(0,0,0,0,1));
        cyc("a_edit_ign", 0,0,2,1,0,0,0, ex(0,0,0,0,1));
        for (int i = 1; i <= 9; i++) begin
            cyc("a_hold", 0,1,0,0,0,0,0, ex(0,0,0,0,1));
            cyc("a_gap", 0,0,0,0,0,0,0, ex(0,0,0,0,1));
        end
        cyc("a_tick10", 0,1,0,0,0,0,0, ex(0,0,0,0,0));
        cyc("a_zero_start", 0,0,0,0,0,1,0, ex(0,0,0,0,0));

        // same again, acknowledged by stop after 3 ticks
        cyc("b_set1", 0,0,2,1,0,0,0, ex(0,0,1,0,0));
        cyc("b_set2", 0,0,2,1,0,0,0, ex(0,0,2,0,0));
        cyc("b_start", 0,0,0,0,0,1,0, ex(0,0,2,1,0));
        cyc("b_tick1", 0,1,0,0,0,0,0, ex(0,0,1,1,0));
        cyc("b_tick2", 0,1,0,0,0,0,0, ex(0,0,0,0,1));
        for (int i = 1; i <= 3; i++)
            cyc("b_hold", 0,1,0,0,0,0,0, ex(0,0,0,0,1));
        cyc("b_stop", 0,0,0,0,0,0,1, ex(0,0,0,0,0));
        cyc("b_idle", 0,1,0,0,0,0,0, ex(0,0,0,0,0));

        // stop coincident with tick at 00:00:05
        for (int i = 1; i <= 5; i++)
            cyc("c_set", 0,0,2,1,0,0,0, ex(0,0,i,0,0));
        cyc("c_start", 0,0,0,0,0,1,0, ex(0,0,5,1,0));
        cyc("c_stoptick", 0,1,0,0,0,0,1, ex(0,0,5,0,0));
        cyc("c_idletick", 0,1,0,0,0,0,0, ex(0,0,5,0,0));
        cyc("c_restart", 0,0,0,0,0,1,0, ex(0,0,5,1,0));
        cyc("c_tick", 0,1,0,0,0,0,0, ex(0,0,4,1,0));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
